ram_vec_adder: RTL and testbench

- Arithmetic-port master for the single-port shared RAM. It drives the RAM's arith address, write data and write enable, and consumes its registered read data.
- On a start pulse it walks a vector of LEN words. For each index i it reads A[i] and B[i], adds them, and writes R[i] back into the same RAM.
- The host loads operands and collects results over the Avalon side of the RAM; this block performs the computation between those steps.

---
 rtl/ram_vec_adder.sv | 133 +++++++++++++
 tb/tb_ram_vec_adder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_vec_adder.sv
// Vector adder master for the shared RAM arith port: R[i] = A[i] + B[i] for i in 0..len-1.
// Define RAM_VEC_ADDER_CARRY_CHAIN_EN to treat the vector as one multi-precision integer.
module ram_vec_adder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              carry_out,
    output logic [ADDR_W-1:0] addr_arith,
    output logic [DATA_W-1:0] data_arith,
    output logic              we_arith,
    input  logic [DATA_W-1:0] q_arith,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ba_q, ba_d, bb_q, bb_d, br_q, br_d;
    logic [ADDR_W:0]     len_q, len_d, idx_q, idx_d, idx_inc;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic                carry_q, carry_d;
    logic                cin;
    logic [DATA_W:0]     sum;

    // Per-word carry in: the previous word's carry when chained, otherwise 0.
`ifdef RAM_VEC_ADDER_CARRY_CHAIN_EN
    assign cin = carry_q;
`else
    assign cin = 1'b0;
`endif

    assign sum       = {1'b0, opa_q} + {1'b0, q_arith} + {{DATA_W{1'b0}}, cin};
    assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
    assign carry_out = carry_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        ba_d       = ba_q;
        bb_d       = bb_q;
        br_d       = br_q;
        len_d      = len_q;
        idx_d      = idx_q;
        opa_d      = opa_q;
        carry_d    = carry_q;
        busy       = 1'b0;
        done       = 1'b0;
        addr_arith = '0;
        data_arith = '0;
        we_arith   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ba_d    = base_a;
                    bb_d    = base_b;
                    br_d    = base_r;
                    len_d   = len;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = (len == '0) ? S_FIN : S_RD_A;
                end
            end
            S_RD_A: begin
                busy       = 1'b1;
                addr_arith = ba_q + idx_q[ADDR_W-1:0];
                state_d    = S_RD_B;
            end
            S_RD_B: begin
                // The RAM read is registered, so A[i] arrives while B[i] is being addressed.
                busy       = 1'b1;
                addr_arith = bb_q + idx_q[ADDR_W-1:0];
                opa_d      = q_arith;
                state_d    = S_WR;
            end
            S_WR: begin
                busy       = 1'b1;
                addr_arith = br_q + idx_q[ADDR_W-1:0];
                data_arith = sum[DATA_W-1:0];
                we_arith   = 1'b1;
                idx_d      = idx_inc;
`ifdef RAM_VEC_ADDER_CARRY_CHAIN_EN
                carry_d    = sum[DATA_W];
`else
                carry_d    = carry_q | sum[DATA_W];
`endif
                state_d    = (idx_inc == len_q) ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ba_q    <= '0;
            bb_q    <= '0;
            br_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            opa_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ba_q    <= ba_d;
            bb_q    <= bb_d;
            br_q    <= br_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_ram_vec_adder.sv
// Bench for ram_vec_adder: a registered single-port RAM model plus a word-level reference model.
module tb_ram_vec_adder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_a = '0, base_b = '0, base_r = '0;
    logic [11:0] len = '0;
    logic        busy, done, carry_out, we_arith;
    logic [10:0] addr_arith;
    logic [31:0] data_arith;
    logic [31:0] q_arith;
    logic [2:0]  dbg_state;

    ram_vec_adder dut (
        .clock(clock), .reset(reset), .start(start),
        .base_a(base_a), .base_b(base_b), .base_r(base_r), .len(len),
        .busy(busy), .done(done), .carry_out(carry_out),
        .addr_arith(addr_arith), .data_arith(data_arith), .we_arith(we_arith),
        .q_arith(q_arith), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // RAM model with a host-side loader port standing in for the Avalon side.
    logic [31:0] mem [2048];
    logic        ld_we = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clock) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (we_arith) mem[addr_arith] <= data_arith;
        q_arith <= mem[addr_arith];
    end

    // Reference memory image; only touched words are compared.
    logic [31:0] ref_mem [2048];
    bit          touched [2048];
    logic        exp_carry;
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;

    always @(negedge clock) begin
        if (we_arith) we_cnt++;
        else begin
            total++;
            if (data_arith !== 32'h0) begin
                bad++;
                $display("FAIL data_idle: data_arith=%0h while we_arith=0, want 0", data_arith);
            end
        end
    end

    task automatic load_word(input logic [10:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we   = 1'b1;
        @(negedge clock);
        ld_we   = 1'b0;
        ref_mem[a] = d;
        touched[a] = 1'b1;
    endtask

    // Word-by-word definition of the operation, with per-word or chained carry.
    task automatic model_op(input logic [10:0] ba, input logic [10:0] bb, input logic [10:0] br,
                            input logic [11:0] n);
        logic [32:0] s;
        logic        c, ci;
        logic [10:0] ia, ib, ir, o;
        c = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            o  = 11'(i);
            ia = ba + o;
            ib = bb + o;
            ir = br + o;
`ifdef RAM_VEC_ADDER_CARRY_CHAIN_EN
            ci = c;
`else
            ci = 1'b0;
`endif
            s = {1'b0, ref_mem[ia]} + {1'b0, ref_mem[ib]} + {32'h0, ci};
            ref_mem[ir] = s[31:0];
            touched[ir] = 1'b1;
`ifdef RAM_VEC_ADDER_CARRY_CHAIN_EN
            c = s[32];
`else
            c = c | s[32];
`endif
        end
        exp_carry = c;
    endtask

    function automatic int first_diff();
        for (int i = 0; i < 2048; i++)
            if (touched[i] && mem[i] !== ref_mem[i]) return i;
        return -1;
    endfunction

    // Issues start at the current negedge; done_cyc is the number of clock edges from
    // the accepting edge's cycle to the negedge where done is seen (-1 if never).
    task automatic run_op(input logic [10:0] ba, input logic [10:0] bb, input logic [10:0] br,
                          input logic [11:0] n, input int extra_at,
                          output int done_cyc, output int dones);
        int cyc;
        int budget;
        budget   = 3 * int'(n) + 20;
        base_a   = ba;
        base_b   = bb;
        base_r   = br;
        len      = n;
        start    = 1'b1;
        cyc      = 0;
        done_cyc = -1;
        dones    = 0;
        while (cyc < budget) begin
            @(negedge clock);
            cyc++;
            start = (cyc == extra_at);
            if (start) begin
                base_a = ba + 11'd7;
                base_b = bb + 11'd7;
                base_r = br + 11'd64;
                len    = 12'd5;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int wc;
        int dc, dn;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        total++;
        if ({busy, done, we_arith, carry_out} !== 4'b0 || addr_arith !== 11'h0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b carry=%b addr=%0h state=%0d, want all 0",
                     busy, done, we_arith, carry_out, addr_arith, dbg_state);
        end
        for (int i = 0; i < 8; i++) begin
            load_word(11'h200 + 11'(i), $urandom);
            load_word(11'h210 + 11'(i), $urandom);
        end
        base_a = 11'h200; base_b = 11'h210; base_r = 11'h220; len = 12'd8;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (we_arith !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_midop: we=%b busy=%b done=%b state=%0d, want 0 0 0 0",
                     we_arith, busy, done, dbg_state);
        end
        @(negedge clock);
        reset = 1'b0;
        wc = we_cnt;
        repeat (6) @(negedge clock);
        total++;
        if (we_cnt !== wc || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: writes after reset=%0d busy=%b, want 0 0", we_cnt - wc, busy);
        end
        run_op(11'h200, 11'h210, 11'h220, 12'd8, 0, dc, dn);
        model_op(11'h200, 11'h210, 11'h220, 12'd8);
        total++;
        if (dc !== 25 || dn !== 1) begin
            bad++;
            $display("FAIL reset_restart: done at %0d count %0d, want 25 1", dc, dn);
        end
        total++;
        if (first_diff() !== -1) begin
            bad++;
            $display("FAIL reset_restart_ram: first bad word %0h, want none", first_diff());
        end
    endtask

    task automatic test_basic();
        int dc, dn;
        for (int i = 0; i < 4; i++) begin
            load_word(11'h000 + 11'(i), 32'(i + 1));
            load_word(11'h010 + 11'(i), 32'(10 * (i + 1)));
        end
        run_op(11'h000, 11'h010, 11'h020, 12'd4, 0, dc, dn);
        model_op(11'h000, 11'h010, 11'h020, 12'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[11'h020 + 11'(i)] !== 32'(11 * (i + 1))) begin
                bad++;
                $display("FAIL basic_r%0d: got %0d want %0d", i, mem[11'h020 + 11'(i)], 11 * (i + 1));
            end
        end
        // Done lands 13 edges after the start cycle, i.e. in the 14th cycle counting the start cycle.
        total++;
        if (dc !== 13 || dn !== 1) begin
            bad++;
            $display("FAIL basic_latency: done at %0d count %0d, want 13 1", dc, dn);
        end
        total++;
        if (carry_out !== 1'b0) begin
            bad++;
            $display("FAIL basic_carry: got %b want 0", carry_out);
        end
    endtask

    task automatic test_wrap_inplace();
        int dc, dn;
        logic [10:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 11'h7FE + 11'(i);
            load_word(a, 32'(5 + i));
            load_word(11'h100 + 11'(i), 32'd1);
        end
        run_op(11'h7FE, 11'h100, 11'h7FE, 12'd4, 0, dc, dn);
        model_op(11'h7FE, 11'h100, 11'h7FE, 12'd4);
        for (int i = 0; i < 4; i++) begin
            a = 11'h7FE + 11'(i);
            total++;
            if (mem[a] !== 32'(6 + i)) begin
                bad++;
                $display("FAIL wrap_r%0d: addr %0h got %0d want %0d", i, a, mem[a], 6 + i);
            end
        end
    endtask

    task automatic test_len_zero();
        int wc, cyc, dcyc, dn;
        bit addr_moved;
        wc = we_cnt;
        addr_moved = 1'b0;
        dcyc = -1;
        dn = 0;
        base_a = 11'h123; base_b = 11'h456; base_r = 11'h789; len = 12'd0;
        start = 1'b1;
        for (cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (addr_arith !== 11'h0) addr_moved = 1'b1;
            if (done) begin
                dn++;
                if (dcyc < 0) dcyc = cyc;
            end
        end
        total++;
        if (we_cnt !== wc || addr_moved) begin
            bad++;
            $display("FAIL len0_access: writes=%0d addr_moved=%b, want 0 0", we_cnt - wc, addr_moved);
        end
        total++;
        if (dcyc !== 1 || dn !== 1) begin
            bad++;
            $display("FAIL len0_done: done at %0d count %0d, want 1 1", dcyc, dn);
        end
        total++;
        if (carry_out !== 1'b0) begin
            bad++;
            $display("FAIL len0_carry: got %b want 0", carry_out);
        end
    endtask

    task automatic test_carry();
        int dc, dn;
        logic [31:0] e0, e1;
        logic        ec;
        load_word(11'h300, 32'hFFFF_FFFF);
        load_word(11'h301, 32'h0);
        load_word(11'h310, 32'h1);
        load_word(11'h311, 32'h0);
        run_op(11'h300, 11'h310, 11'h320, 12'd2, 0, dc, dn);
        model_op(11'h300, 11'h310, 11'h320, 12'd2);
`ifdef RAM_VEC_ADDER_CARRY_CHAIN_EN
        e0 = 32'h0; e1 = 32'h1; ec = 1'b0;
`else
        e0 = 32'h0; e1 = 32'h0; ec = 1'b1;
`endif
        total++;
        if (mem[11'h320] !== e0 || mem[11'h321] !== e1) begin
            bad++;
            $display("FAIL carry_words: got %0h %0h want %0h %0h", mem[11'h320], mem[11'h321], e0, e1);
        end
        total++;
        if (carry_out !== ec) begin
            bad++;
            $display("FAIL carry_out: got %b want %b", carry_out, ec);
        end
    endtask

    task automatic test_start_while_busy();
        int dc, dn;
        for (int i = 0; i < 6; i++) begin
            load_word(11'h400 + 11'(i), $urandom);
            load_word(11'h440 + 11'(i), $urandom);
            load_word(11'h480 + 11'(i), 32'h0);
        end
        run_op(11'h400, 11'h440, 11'h480 - 11'd64, 12'd6, 4, dc, dn);
        model_op(11'h400, 11'h440, 11'h480 - 11'd64, 12'd6);
        total++;
        if (dn !== 1 || dc !== 19) begin
            bad++;
            $display("FAIL busy_start_done: count %0d at %0d, want 1 at 19", dn, dc);
        end
        total++;
        if (first_diff() !== -1) begin
            bad++;
            $display("FAIL busy_start_ram: first bad word %0h, want none", first_diff());
        end
    endtask

    task automatic test_random();
        int dc, dn, sel, exp_dc;
        logic [10:0] ba, bb, br;
        logic [11:0] n;
        for (int k = 0; k < 8; k++) begin
            ba  = 11'($urandom_range(0, 2047));
            bb  = ba + 11'd512;
            sel = int'($urandom_range(0, 2));
            br  = (sel == 0) ? ba : (sel == 1) ? bb : ba + 11'd1024;
            n   = 12'($urandom_range(1, 24));
            for (int i = 0; i < int'(n); i++) begin
                load_word(ba + 11'(i), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
                load_word(bb + 11'(i), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
            end
            run_op(ba, bb, br, n, 0, dc, dn);
            model_op(ba, bb, br, n);
            exp_dc = 3 * int'(n) + 1;
            total++;
            if (dc !== exp_dc || dn !== 1) begin
                bad++;
                $display("FAIL rand%0d_done: at %0d count %0d, want %0d 1", k, dc, dn, exp_dc);
            end
            total++;
            if (carry_out !== exp_carry) begin
                bad++;
                $display("FAIL rand%0d_carry: got %b want %b", k, carry_out, exp_carry);
            end
            total++;
            if (first_diff() !== -1) begin
                bad++;
                $display("FAIL rand%0d_ram: first bad word %0h, want none", k, first_diff());
            end
        end
    endtask

    // Whole RAM as one in-place vector: R = A + A over all 2048 words, crossing the wrap point.
    task automatic test_full_length();
        int dc, dn;
        for (int i = 0; i < 2048; i++) load_word(11'(i), $urandom);
        run_op(11'h155, 11'h155, 11'h155, 12'd2048, 0, dc, dn);
        model_op(11'h155, 11'h155, 11'h155, 12'd2048);
        total++;
        if (dc !== 6145 || dn !== 1) begin
            bad++;
            $display("FAIL full_done: at %0d count %0d, want 6145 1", dc, dn);
        end
        total++;
        if (carry_out !== exp_carry) begin
            bad++;
            $display("FAIL full_carry: got %b want %b", carry_out, exp_carry);
        end
        total++;
        if (first_diff() !== -1) begin
            bad++;
            $display("FAIL full_ram: first bad word %0h, want none", first_diff());
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) touched[i] = 1'b0;
        exp_carry = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_wrap_inplace();
        test_len_zero();
        test_carry();
        test_start_while_busy();
        test_random();
        test_full_length();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
